branch_resolve_queue: RTL and testbench

In-order tracker between fetch-stage branch prediction and execute-stage branch resolution. Every predicted branch enters a FIFO holding its table index and predicted direction. Execute resolves branches oldest-first; the block then emits one update (index, actual direction) to the branch history table, and a mispredict pulse that flushes wrong-path entries.

---
 rtl/branch_resolve_queue_pkg.sv | 25 ++
 rtl/branch_resolve_queue_bp_fifo.sv | 64 ++++++
 rtl/branch_resolve_queue.sv | 100 ++++++++++
 tb/tb_branch_resolve_queue.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_queue_pkg.sv
// Shared types and default sizing for the branch predictor pipeline:
// fetch, the resolve queue and the branch history table all import these.
package branch_resolve_queue_pkg;

  localparam int BRQ_DEPTH = 4;
  localparam int BRQ_IDX_W = 5;

  typedef struct packed {
    logic [BRQ_IDX_W-1:0] idx;
    logic                 taken;
  } brq_entry_t;

  typedef enum logic [1:0] {
    MODE_EMPTY   = 2'd0,
    MODE_PARTIAL = 2'd1,
    MODE_FULL    = 2'd2
  } brq_mode_e;

  function automatic brq_mode_e brq_mode_of(input int unsigned cnt, input int unsigned depth);
    if (cnt == 0) return MODE_EMPTY;
    if (cnt >= depth) return MODE_FULL;
    return MODE_PARTIAL;
  endfunction

endpackage

// File: rtl/branch_resolve_queue_bp_fifo.sv
// Generic DEPTH x W register FIFO. Clear empties the queue by snapping the
// write pointer onto the (post-pop) read pointer; a same-cycle push is dropped.
module bp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [W-1:0]     rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full && !clear;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (clear) begin
      wr_ptr_d = rd_ptr_d;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; it is never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order branch tracker: queues predictions from fetch, pairs each with its
// execute-stage resolution, and emits a registered table update plus flush.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  parameter int IDX_W = BRQ_IDX_W,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_valid,
  input  logic [IDX_W-1:0] pred_idx,
  input  logic             pred_taken,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_addr,
  output logic             upd_taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  localparam int ENT_W = IDX_W + 1;

  logic [ENT_W-1:0] head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  brq_mode_e        mode;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;
  logic             pop_ok, mis, push;

  logic             upd_valid_q, upd_valid_d;
  logic [IDX_W-1:0] upd_addr_q, upd_addr_d;
  logic             upd_taken_q, upd_taken_d;
  logic             mispredict_q, mispredict_d;
  logic             underflow_q, underflow_d;

  bp_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({pred_idx, pred_taken}),
    .pop       (res_valid),
    .clear     (mis),
    .rd_data   (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign mode       = brq_mode_of(32'(fifo_count), DEPTH);
  assign head_idx   = head[ENT_W-1:1];
  assign head_taken = head[0];

  always_comb begin
    pop_ok       = res_valid && (mode != MODE_EMPTY);
    mis          = pop_ok && (head_taken != res_taken);
    // A mismatching pop makes anything fetched this cycle wrong-path.
    push         = pred_valid && !fifo_full && !mis;
    upd_valid_d  = pop_ok;
    upd_addr_d   = pop_ok ? head_idx : upd_addr_q;
    upd_taken_d  = pop_ok ? res_taken : upd_taken_q;
    mispredict_d = mis;
    underflow_d  = underflow_q || (res_valid && fifo_empty);
  end

  // Registered update stage
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_valid_q  <= 1'b0;
      upd_addr_q   <= '0;
      upd_taken_q  <= 1'b0;
      mispredict_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      upd_valid_q  <= upd_valid_d;
      upd_addr_q   <= upd_addr_d;
      upd_taken_q  <= upd_taken_d;
      mispredict_q <= mispredict_d;
      underflow_q  <= underflow_d;
    end
  end

  assign pred_ready = !fifo_full;
  assign count      = fifo_count;
  assign upd_valid  = upd_valid_q;
  assign upd_addr   = upd_addr_q;
  assign upd_taken  = upd_taken_q;
  assign mispredict = mispredict_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: resolves queue an expected update
// in a scoreboard; a negedge monitor matches every DUT update against it.
module tb_branch_resolve_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       pred_valid;
  logic [4:0] pred_idx;
  logic       pred_taken;
  logic       pred_ready;
  logic       res_valid;
  logic       res_taken;
  logic       upd_valid;
  logic [4:0] upd_addr;
  logic       upd_taken;
  logic       mispredict;
  logic [2:0] count;
  logic       underflow;

  typedef struct {
    logic [4:0] addr;
    logic       taken;
    logic       mis;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;

  branch_resolve_queue #(.DEPTH(4), .IDX_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .pred_valid (pred_valid),
    .pred_idx   (pred_idx),
    .pred_taken (pred_taken),
    .pred_ready (pred_ready),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .upd_valid  (upd_valid),
    .upd_addr   (upd_addr),
    .upd_taken  (upd_taken),
    .mispredict (mispredict),
    .count      (count),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_upd(input logic [4:0] addr, input logic taken, input logic mis);
    exp_t e;
    e.addr  = addr;
    e.taken = taken;
    e.mis   = mis;
    e.cyc   = cyc + 1;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic pv, input logic [4:0] pi, input logic pt,
                       input logic rv, input logic rt);
    pred_valid = pv;
    pred_idx   = pi;
    pred_taken = pt;
    res_valid  = rv;
    res_taken  = rt;
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (upd_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_update: got addr=%0d taken=%0d mis=%0d expected no update (cycle %0d)",
                   upd_addr, upd_taken, mispredict, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("upd_cycle", cyc, e.cyc);
          chk("upd_addr", upd_addr, e.addr);
          chk("upd_taken", upd_taken, e.taken);
          chk("mispredict", mispredict, e.mis);
        end
      end else begin
        chk("mispredict_idle", mispredict, 0);
        if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
          exp_t e;
          e = sbq.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_update: got upd_valid=%0d expected update addr=%0d taken=%0d (cycle %0d)",
                   upd_valid, e.addr, e.taken, cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; pred_valid = 1'b0; pred_idx = '0; pred_taken = 1'b0;
    res_valid = 1'b0; res_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Reset state and idle
    chk("reset_upd_addr", upd_addr, 0);
    chk("reset_upd_taken", upd_taken, 0);
    for (int i = 0; i < 10; i++) begin
      chk("idle_pred_ready", pred_ready, 1);
      chk("idle_count", count, 0);
      chk("idle_underflow", underflow, 0);
      drive(0, 0, 0, 0, 0);
    end

    // Two correct predictions
    drive(1, 3, 1, 0, 0);
    drive(1, 7, 0, 0, 0);
    chk("two_count", count, 2);
    expect_upd(3, 1, 0); drive(0, 0, 0, 1, 1);
    expect_upd(7, 0, 0); drive(0, 0, 0, 1, 0);
    chk("two_drained", count, 0);
    drive(0, 0, 0, 0, 0);
    chk("hold_addr", upd_addr, 7);
    chk("hold_taken", upd_taken, 0);

    // Fill, overflow attempt, pop frees a slot
    for (int i = 1; i <= 4; i++) drive(1, 5'(i), 1, 0, 0);
    chk("full_count", count, 4);
    chk("full_ready", pred_ready, 0);
    drive(1, 30, 1, 0, 0);
    chk("drop_count", count, 4);
    expect_upd(1, 1, 0); drive(0, 0, 0, 1, 1);
    chk("after_pop_ready", pred_ready, 1);
    chk("after_pop_count", count, 3);
    for (int i = 2; i <= 4; i++) begin
      expect_upd(5'(i), 1, 0);
      drive(0, 0, 0, 1, 1);
    end
    chk("fill_drained", count, 0);

    // Mispredict flush with wrong-path push
    drive(1, 5, 1, 0, 0);
    drive(1, 9, 1, 0, 0);
    drive(1, 12, 0, 0, 0);
    expect_upd(5, 0, 1); drive(1, 20, 1, 1, 0);
    chk("flush_count", count, 0);
    chk("flush_ready", pred_ready, 1);

    // Resolve while empty
    drive(0, 0, 0, 1, 1);
    chk("underflow_set", underflow, 1);
    chk("underflow_count", count, 0);
    drive(1, 6, 0, 1, 1);
    chk("empty_res_push_count", count, 1);
    expect_upd(6, 0, 0); drive(0, 0, 0, 1, 0);
    chk("underflow_sticky", underflow, 1);
    reset = 1'b1; drive(0, 0, 0, 0, 0); reset = 1'b0;
    chk("underflow_cleared", underflow, 0);

    // Wrap-around rounds
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++) drive(1, 5'(r * 3 + k), 1'((r + k) & 1), 0, 0);
      for (int k = 0; k < 3; k++) begin
        expect_upd(5'(r * 3 + k), 1'((r + k) & 1), 0);
        drive(0, 0, 0, 1, 1'((r + k) & 1));
      end
    end
    chk("wrap_count", count, 0);

    // Reset mid-sequence with a resolve pending
    drive(1, 13, 1, 0, 0);
    drive(1, 14, 0, 0, 0);
    reset = 1'b1; drive(0, 0, 0, 1, 1); reset = 1'b0;
    chk("midreset_count", count, 0);
    chk("midreset_ready", pred_ready, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 15, 1, 0, 0);
    expect_upd(15, 1, 0); drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0);
    chk("final_count", count, 0);
    chk("final_underflow", underflow, 0);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
